// File: rtl/bm_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 8-bit ALU among four requesters.
// Optional macro ALU_MUL_EN adds an 8x8 multiplier and MULW state; otherwise op 011 is reserved.
module bm_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op_in,
  input  logic [WIDTH*N_REQ-1:0] a_in,
  input  logic [WIDTH*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [2*WIDTH-1:0]     res_out,
  output logic                   res_valid,
  output logic [1:0]             res_id,
  output logic [7:0]             op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
`ifdef ALU_MUL_EN
    , MULW = 2'd3
`endif
  } state_t;

  localparam logic [2*WIDTH-1:0] RESERVED_RES = (2*WIDTH)'(16'h00CD);

  state_t               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [2*WIDTH-1:0]   res_out_q, res_out_d;
  logic                 res_valid_q, res_valid_d;
  logic [1:0]           res_id_q, res_id_d;
  logic [7:0]           op_count_q, op_count_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           id_q, id_d;

  logic                 found;
  logic [1:0]           win;
  logic [1:0]           idx;
  logic [2*WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0]   a_ext, b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  // First asserted request at or above rr_ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000: alu_res = a_ext & b_ext;
      3'b001: alu_res = a_ext | b_ext;
      3'b010: alu_res = a_ext ^ b_ext;
      3'b100: alu_res = a_ext + b_ext;
      3'b101: alu_res = a_ext - b_ext;
      3'b110: alu_res = ~a_ext & b_ext;
      default: alu_res = RESERVED_RES;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    res_out_d   = res_out_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_d       = op_in[3*int'(win) +: 3];
          a_d        = a_in[WIDTH*int'(win) +: WIDTH];
          b_d        = b_in[WIDTH*int'(win) +: WIDTH];
          id_d       = win;
          gnt_d[win] = 1'b1;
          rr_ptr_d   = win + 2'd1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_out_d   = alu_res;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        op_count_d  = op_count_q + 8'd1;
        state_d     = RESP;
`ifdef ALU_MUL_EN
        // Multiply defers its result to MULW so res_out keeps the previous result meanwhile.
        if (op_q == 3'b011) begin
          res_out_d   = res_out_q;
          res_valid_d = 1'b0;
          res_id_d    = res_id_q;
          op_count_d  = op_count_q;
          state_d     = MULW;
        end
`endif
      end
`ifdef ALU_MUL_EN
      MULW: begin
        res_out_d   = a_ext * b_ext;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        op_count_d  = op_count_q + 8'd1;
        state_d     = RESP;
      end
`endif
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      op_count_q  <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      res_out_q   <= res_out_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_out   = res_out_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_bm_alu_arbiter.sv
// Directed table-driven bench for bm_alu_arbiter: per-op timing/results, round robin,
// reset abort, and op_count wrap. Expected MUL result follows ALU_MUL_EN.
module tb_bm_alu_arbiter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] op_in = '0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [15:0] res_out;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  op_count;

  bm_alu_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_out(res_out), .res_valid(res_valid), .res_id(res_id),
    .op_count(op_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    op_in[3*id +: 3] = op;
    a_in[8*id +: 8]  = a;
    b_in[8*id +: 8]  = b;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{0, 3'b100, 8'hFF, 8'h01, 16'h0100};
    vecs[1] = '{1, 3'b101, 8'h03, 8'h05, 16'hFFFE};
    vecs[2] = '{2, 3'b110, 8'hF0, 8'hFF, 16'h000F};
    vecs[3] = '{3, 3'b111, 8'h12, 8'h34, 16'h00CD};
`ifdef ALU_MUL_EN
    vecs[4] = '{0, 3'b011, 8'hFF, 8'hFF, 16'hFE01};
`else
    vecs[4] = '{0, 3'b011, 8'hFF, 8'hFF, 16'h00CD};
`endif
    vecs[5] = '{1, 3'b000, 8'hF0, 8'h3C, 16'h0030};
    vecs[6] = '{2, 3'b001, 8'hF0, 8'h0F, 16'h00FF};
    vecs[7] = '{3, 3'b010, 8'hAA, 8'hFF, 16'h0055};
    vecs[8] = '{2, 3'b100, 8'h80, 8'h80, 16'h0100};
    vecs[9] = '{0, 3'b101, 8'h10, 8'h01, 16'h000F};

    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_op_count", op_count, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      req = '0;
      req[vecs[i].id] = 1'b1;
      load(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk("gnt", gnt, 32'(1) << vecs[i].id);
      chk("busy_exec", busy, 1);
      req = '0;
      op_in = ~op_in;
      a_in = ~a_in;
      b_in = ~b_in;
      tick();
`ifdef ALU_MUL_EN
      if (vecs[i].op == 3'b011) begin
        chk("mulw_no_valid", res_valid, 0);
        tick();
      end
`endif
      exp_cnt++;
      chk("res_valid", res_valid, 1);
      chk("res_out", res_out, vecs[i].exp);
      chk("res_id", res_id, vecs[i].id);
      chk("op_count", op_count, exp_cnt);
      chk("gnt_off", gnt, 0);
      tick();
      chk("valid_drop", res_valid, 0);
      chk("busy_idle", busy, 0);
      chk("res_hold", res_out, vecs[i].exp);
    end

    // Abort mid-operation: rr_ptr would point at 3 without reset.
    req = 4'b0100;
    load(2, 3'b000, 8'hFF, 8'hFF);
    tick();
    chk("abort_gnt", gnt, 4'b0100);
    reset_n = 1'b0;
    #1;
    chk("abort_gnt0", gnt, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_res_out0", res_out, 0);
    chk("abort_op_count0", op_count, 0);
    tick();
    tick();
    chk("abort_no_valid", res_valid, 0);
    req = 4'b1010;
    reset_n = 1'b1;
    tick();
    chk("post_rst_gnt", gnt, 4'b0010);
    chk("post_rst_no_valid", res_valid, 0);
    req = '0;
    tick();
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_id", res_id, 1);
    chk("post_rst_count", op_count, 1);
    tick();

    // Round robin with all four requesting continuously.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    op_in = '0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt", gnt, 32'(1) << (g % 4));
      tick();
      chk("rr_gap_resp", gnt, 0);
      tick();
      chk("rr_gap_idle", gnt, 0);
    end
    req = '0;
    tick();

    // op_count wrap after 256 completions.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    req = 4'b0001;
    for (int n = 1; n <= 256; n++) begin
      wait_valid(ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout: no res_valid for op %0d", n);
        break;
      end
      if (n == 255) chk("wrap_255", op_count, 255);
      if (n == 256) chk("wrap_0", op_count, 0);
    end
    req = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bm_alu_arbiter.md
# bm_alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU datapath (AND/OR/XOR/MUL/ADD/SUB/AND-NOT) between four requesters. It grants one requester at a time, latches that requester's opcode and operands, and executes the operation in a registered datapath. It returns a 16-bit result tagged with the requester ID and keeps a wrapping count of completed operations. It sits in front of the micro-benchmark functional datapath as its controller.

## Interface
- `N_REQ`, 4 — number of requesters; fixed at 4, which sets the 2-bit `res_id`.
- `WIDTH`, 8 — operand width; results are `2*WIDTH`.
- `clock`  in  1  — rising-edge clock.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `req`  in  4  — request per requester; level, held until own `gnt` seen.
- `op_in`  in  12  — packed 3-bit opcodes; requester i uses bits [3i+2:3i].
- `a_in`  in  32  — packed operand A; requester i uses bits [8i+7:8i].
- `b_in`  in  32  — packed operand B, same packing as `a_in`.
- `gnt`  out  4  — one-hot grant, high for exactly one cycle.
- `busy`  out  1  — high whenever state is not IDLE.
- `res_out`  out  16  — result; held until the next result.
- `res_valid`  out  1  — one-cycle strobe marking `res_out`/`res_id` valid.
- `res_id`  out  2  — index of the requester that owns `res_out`.
- `op_count`  out  8  — number of completed operations; wraps 255→0.

## Operation
- FSM states: IDLE, EXEC, MULW (only when `ALU_MUL_EN` is defined), RESP.
- **IDLE**
  - If `|req`, pick the first asserted requester scanning from `rr_ptr` upward mod 4.
  - Latch that requester's op/a/b, set `gnt[winner]`, set `rr_ptr` = winner+1 mod 4, go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - `gnt` is high in this state only.
  - Register the result into `res_out`.
  - Go to MULW if op=011 and `ALU_MUL_EN` is defined; otherwise go to RESP.
- **MULW**: complete the product into `res_out`, go to RESP.
- **RESP**: `res_valid`=1, `res_id`=latched winner, `op_count`++, go to IDLE.
- Opcodes and 16-bit result rules:
  - 000: a&b
  - 001: a|b
  - 010: a^b
  - 011: a*b, unsigned
  - 100: a+b, with carry in bit 8
  - 101: a−b, computed at 16 bits two's complement (3−5=0xFFFE)
  - 110: ~a&b
  - 111: reserved, returns 0x00CD
  - Logical results are zero-extended.
- Only the latched copy of op/a/b is used; input changes after the grant are ignored.
- A requester that holds `req` high after its RESP re-arbitrates normally. Round-robin still prevents starvation.
- Reset values (asynchronous): state IDLE, `rr_ptr`=0, and all outputs 0 (`gnt`, `busy`, `res_out`, `res_valid`, `res_id`, `op_count`).
- Reset asserted mid-operation aborts immediately. The in-flight op is discarded, no `res_valid` is produced, and `op_count` is not incremented.

## Timing
- Request sampled at edge k while in IDLE: `gnt` and `busy` are high in cycle k+1.
- Non-MUL op: `res_valid` is high in cycle k+2; the FSM is in IDLE in cycle k+3.
- MUL with `ALU_MUL_EN` defined: `res_valid` is high in cycle k+3.
- Back-to-back issue rate: one op per 3 cycles (4 for MUL).
- Requests arriving while `busy` are not granted until the next IDLE cycle.
- `busy` is 0 during IDLE only, including the IDLE cycle right after RESP.
- `op_count` updates on the same edge that raises `res_valid`.

## Configuration
- Macro: `ALU_MUL_EN`.
- Defined:
  - op 011 runs through the 8×8 unsigned multiplier.
  - It takes the extra MULW state and produces the full 16-bit product.
- Undefined:
  - No multiplier or MULW state is built.
  - op 011 is treated as reserved and returns 0x00CD with standard 3-cycle timing.

## Test plan
- Reset, then `req`=0001, op=100, a=0xFF, b=0x01 → `gnt`=0001 one cycle later; `res_out`=0x0100, `res_id`=0 two cycles after the sample; `op_count`=1.
- `req`=1111 held continuously, all op=000 → grants in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- op=101, a=3, b=5 → 0x FFFE. op=110, a=0xF0, b=0xFF → 0x000F. op=111 → 0x00CD.
- op=011, a=0xFF, b=0xFF:
  - `ALU_MUL_EN` defined → 0xFE01, `res_valid` at k+3.
  - `ALU_MUL_EN` undefined → 0x00CD at k+2.
- Assert `reset_n`=0 during EXEC → all outputs 0 immediately, no `res_valid` after release, next grant goes to the lowest asserted requester.
- Issue 256 ops → `op_count` wraps 255→0.
